frame_capture_ctrl: RTL

Sequences one camera frame (8-bit parallel bus, HSYNC/VSYNC/PXCLK) into external byte-wide memory in the system `clock` domain. Synchronises the camera strobes, detects frame and line boundaries, buffers pixel bytes in a small FIFO and issues write requests with a ready handshake at incrementing addresses. Sits between the camera pins and the memory port of the frame-grab top level; the camera clock comes from the existing clock divider.

---
 rtl/frame_capture_ctrl_pkg.sv | 16 +
 rtl/capture_fifo.sv | 37 +++
 rtl/frame_capture_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/frame_capture_ctrl_pkg.sv
// frame_capture_ctrl_pkg: shared FSM states, default frame geometry and FIFO sizing helper.
package frame_capture_ctrl_pkg;
  typedef enum logic [2:0] {
    IDLE,
    WAIT_VS_HIGH,
    WAIT_VS_LOW,
    CAPTURE,
    DRAIN,
    DONE
  } state_t;
  localparam int DEF_H_BYTES = 1280;
  localparam int DEF_V_LINES = 480;
  function automatic int ptr_width(input int depth);
    return depth > 2 ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/capture_fifo.sv
// capture_fifo: synchronous power-of-two FIFO; a push into a full FIFO is accepted only alongside a pop.
module capture_fifo import frame_capture_ctrl_pkg::*; #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          empty,
  output logic          drop
);
  localparam int PW = ptr_width(DEPTH);
  logic [DW-1:0] mem [DEPTH];
  logic [PW:0] wr_ptr, rd_ptr;
  logic full, do_push, do_pop;
  assign empty   = wr_ptr == rd_ptr;
  assign full    = wr_ptr[PW-1:0] == rd_ptr[PW-1:0] && wr_ptr[PW] != rd_ptr[PW];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && !do_push;
  assign dout    = mem[rd_ptr[PW-1:0]];
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (do_pop) rd_ptr <= rd_ptr + (PW+1)'(1);
    end
  end
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr[PW-1:0]] <= din;
endmodule

// File: rtl/frame_capture_ctrl.sv
// frame_capture_ctrl: camera frame grabber writing bytes to memory via a ready handshake.
// Define CAPTURE_CHECK_EN to add the line-length/line-count checker and its frameError output.
module frame_capture_ctrl import frame_capture_ctrl_pkg::*; #(
  parameter int                    ADDR_WIDTH = 23,
  parameter int                    DATA_WIDTH = 8,
  parameter int                    H_BYTES    = DEF_H_BYTES,
  parameter int                    V_LINES    = DEF_V_LINES,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    FIFO_DEPTH = 4
) (
  input  logic                  clock,
  input  logic                  resetN,
  input  logic                  start,
  input  logic                  continuous,
  input  logic                  abort,
  input  logic [DATA_WIDTH-1:0] cameraData,
  input  logic                  HSYNC,
  input  logic                  VSYNC,
  input  logic                  PXCLK,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic [DATA_WIDTH-1:0] memData,
  output logic                  memWrite,
  input  logic                  memReady,
  output logic                  busy,
  output logic                  frameDone,
  output logic                  overflow
`ifdef CAPTURE_CHECK_EN
  , output logic                frameError
`endif
);
  localparam int TOTAL = H_BYTES * V_LINES;
  localparam int CW    = $clog2(TOTAL + 1);
  state_t state, nxt;
  logic [2:0] px_s, vs_s;
  logic [1:0] hs_s;
  logic [DATA_WIDTH-1:0] d_s1, d_s2, fifo_dout;
  logic [CW-1:0] byte_cnt;
  logic cont_r, fifo_empty, fifo_drop;
  logic px_rise, vs_rise, vs_fall, abort_act, start_act, push, load, enter_cap;
  assign px_rise   = px_s[1] && !px_s[2];
  assign vs_rise   = vs_s[1] && !vs_s[2];
  assign vs_fall   = !vs_s[1] && vs_s[2];
  assign abort_act = abort && state != IDLE;
  assign start_act = start && !abort && state == IDLE;
  assign push      = state == CAPTURE && px_rise && hs_s[1] && byte_cnt < CW'(TOTAL) && !abort_act;
  assign load      = (state == CAPTURE || state == DRAIN) && !abort_act && (!memWrite || memReady);
  assign enter_cap = state == WAIT_VS_LOW && nxt == CAPTURE;
  assign busy      = state != IDLE;
  assign frameDone = state == DONE;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:         nxt = start_act ? WAIT_VS_HIGH : IDLE;
      WAIT_VS_HIGH: nxt = vs_rise ? WAIT_VS_LOW : WAIT_VS_HIGH;
      WAIT_VS_LOW:  nxt = vs_fall ? CAPTURE : WAIT_VS_LOW;
      CAPTURE:      nxt = (vs_rise || byte_cnt == CW'(TOTAL)) ? DRAIN : CAPTURE;
      DRAIN:        nxt = (fifo_empty && !memWrite) ? DONE : DRAIN;
      DONE:         nxt = cont_r ? WAIT_VS_LOW : IDLE;
      default:      nxt = IDLE;
    endcase
    if (abort_act) nxt = IDLE;
  end
  // The output register is the pending write: an abort flushes the FIFO but leaves it to complete.
  always_ff @(posedge clock) begin
    if (!resetN) begin
      px_s     <= '0;
      vs_s     <= '0;
      hs_s     <= '0;
      d_s1     <= '0;
      d_s2     <= '0;
      state    <= IDLE;
      byte_cnt <= '0;
      cont_r   <= 1'b0;
      overflow <= 1'b0;
      memWrite <= 1'b0;
      memData  <= '0;
      memAddr  <= BASE_ADDR;
    end else begin
      px_s  <= {px_s[1:0], PXCLK};
      vs_s  <= {vs_s[1:0], VSYNC};
      hs_s  <= {hs_s[0], HSYNC};
      d_s1  <= cameraData;
      d_s2  <= d_s1;
      state <= nxt;
      if (start_act) begin
        cont_r   <= continuous;
        overflow <= 1'b0;
      end else if (fifo_drop) overflow <= 1'b1;
      if (enter_cap) byte_cnt <= '0;
      else if (push) byte_cnt <= byte_cnt + CW'(1);
      if (memWrite && memReady) begin
        memWrite <= 1'b0;
        memAddr  <= memAddr + ADDR_WIDTH'(1);
      end
      if (load && !fifo_empty) begin
        memWrite <= 1'b1;
        memData  <= fifo_dout;
      end
      if (enter_cap) memAddr <= BASE_ADDR;
    end
  end
  capture_fifo #(.DW(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clock),
    .rst   (!resetN),
    .flush (abort_act),
    .push  (push),
    .pop   (load),
    .din   (d_s2),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .drop  (fifo_drop)
  );
`ifdef CAPTURE_CHECK_EN
  localparam int LW = $clog2(V_LINES + 1);
  logic hs_d, hs_fall, frame_end;
  logic [CW-1:0] line_cnt;
  logic [LW-1:0] lines;
  assign hs_fall   = state == CAPTURE && hs_d && !hs_s[1];
  assign frame_end = state == CAPTURE && nxt == DRAIN;
  // A frame cut short by the byte limit never sees its last HSYNC fall, so a full byte count counts as complete.
  always_ff @(posedge clock) begin
    if (!resetN) begin
      hs_d       <= 1'b0;
      line_cnt   <= '0;
      lines      <= '0;
      frameError <= 1'b0;
    end else begin
      hs_d <= hs_s[1];
      if (start_act) frameError <= 1'b0;
      else if ((hs_fall && line_cnt != CW'(H_BYTES)) ||
               (frame_end && lines < LW'(V_LINES) && byte_cnt != CW'(TOTAL))) frameError <= 1'b1;
      if (enter_cap || hs_fall) line_cnt <= '0;
      else if (push) line_cnt <= line_cnt + CW'(1);
      if (enter_cap) lines <= '0;
      else if (hs_fall && lines != LW'(V_LINES)) lines <= lines + LW'(1);
    end
  end
`endif
endmodule
